// File: rtl/pcle_pkg.sv
// pcle_pkg: shared types and defaults for the pcle down-timer slice.
package pcle_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} timer_state_t;
   localparam int PCLE_DEF_WIDTH = 8;
endpackage

// File: rtl/pcle_down_timer_if.sv
// pcle_down_timer_if: control/status bundle of the down-timer.
interface pcle_down_timer_if import pcle_pkg::*; #(parameter int WIDTH = PCLE_DEF_WIDTH);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             cnt_en;
   logic             inhibit;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             bout;
   logic             tc;
   logic             busy;
   modport master (output load, load_val, cnt_en, inhibit, auto_reload,
                   input  count, bout, tc, busy);
   modport slave  (input  load, load_val, cnt_en, inhibit, auto_reload,
                   output count, bout, tc, busy);
endinterface

// File: rtl/pcle_dec_stage.sv
// pcle_dec_stage: combinational ripple decrementer; a bit toggles when all lower bits are zero.
module pcle_dec_stage #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] q,
   input  logic             en,
   output logic [WIDTH-1:0] q_next,
   output logic             borrow
);
   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         assign q_next[i] = q[i] ^ en;
      end else begin : g_upper
         assign q_next[i] = q[i] ^ (en & ~|q[i-1:0]);
      end
   end
   assign borrow = en & ~|q;
endmodule

// File: rtl/pcle_down_timer.sv
// pcle_down_timer: loadable down-counter with cascadable borrow and one-shot/auto-reload expiry.
module pcle_down_timer import pcle_pkg::*; #(parameter int WIDTH = PCLE_DEF_WIDTH) (
   input logic              clk,
   input logic              rst_n,
   pcle_down_timer_if.slave bus
);
   timer_state_t     state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d, q_next;
   logic             tc_q, tc_d, dec, borrow;
   assign dec = bus.cnt_en & ~bus.inhibit & ~bus.load & (state_q == RUN);
   pcle_dec_stage #(.WIDTH(WIDTH)) u_dec (
      .q      (count_q),
      .en     (dec),
      .q_next (q_next),
      .borrow (borrow)
   );
   // expiry (borrow) replaces the wrap below zero
   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      state_d  = state_q;
      tc_d     = 1'b0;
      if (bus.load) begin
         count_d  = bus.load_val;
         reload_d = bus.load_val;
         state_d  = RUN;
      end else if (borrow) begin
         tc_d    = 1'b1;
         count_d = bus.auto_reload ? reload_q : count_q;
         state_d = bus.auto_reload ? RUN : DONE;
      end else if (dec) begin
         count_d = q_next;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         reload_q <= '0;
         state_q  <= IDLE;
         tc_q     <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         state_q  <= state_d;
         tc_q     <= tc_d;
      end
   end
   assign bus.count = count_q;
   assign bus.bout  = borrow;
   assign bus.tc    = tc_q;
   assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_pcle_down_timer.sv
// tb_pcle_down_timer: scoreboard bench for the down-timer, single and cascaded.
module tb_pcle_down_timer;
   typedef struct packed {logic [7:0] count; logic tc; logic busy;} exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [15:0] csb[$];
   pcle_down_timer_if #(.WIDTH(8)) bus ();
   pcle_down_timer_if #(.WIDTH(8)) lo_if ();
   pcle_down_timer_if #(.WIDTH(8)) hi_if ();
   pcle_down_timer #(.WIDTH(8)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
   pcle_down_timer #(.WIDTH(8)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(lo_if));
   pcle_down_timer #(.WIDTH(8)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(hi_if));
   assign hi_if.cnt_en = lo_if.bout;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic ld, input logic [7:0] v, input logic en, input logic inh, input logic ar);
      bus.load        = ld;
      bus.load_val    = v;
      bus.cnt_en      = en;
      bus.inhibit     = inh;
      bus.auto_reload = ar;
   endtask
   task automatic test_reset;
      exp_t e;
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      lo_if.load = 1'b0; lo_if.load_val = 8'h00; lo_if.cnt_en = 1'b0; lo_if.inhibit = 1'b0; lo_if.auto_reload = 1'b0;
      hi_if.load = 1'b0; hi_if.load_val = 8'h00; hi_if.inhibit = 1'b0; hi_if.auto_reload = 1'b0;
      #2;
      checks++;
      if ({bus.count, bus.tc, bus.busy, bus.bout} !== 11'h000) begin
         errors++;
         $display("FAIL reset_state: count=%h tc=%b busy=%b bout=%b, want 00 0 0 0", bus.count, bus.tc, bus.busy, bus.bout);
      end
      #11 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.bout !== 1'b0) begin
            errors++;
            $display("FAIL idle_bout cyc %0d: got %b want 0", i, bus.bout);
         end
         sb.push_back('{8'h00, 1'b0, 1'b0});
         tick;
         e = sb.pop_front();
         checks++;
         if ({bus.count, bus.tc, bus.busy} !== e) begin
            errors++;
            $display("FAIL idle cyc %0d: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                     i, bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
         end
      end
   endtask
   task automatic test_one_shot;
      logic [7:0] cnt_e [7] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      logic [6:0] tc_e   = 7'b0010000;
      logic [6:0] busy_e = 7'b0001111;
      logic [6:0] bout_e = 7'b0010000;
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         drive(i == 0, 8'd3, 1'b1, 1'b0, 1'b0);
         #1;
         checks++;
         if (bus.bout !== bout_e[i]) begin
            errors++;
            $display("FAIL one_shot_bout row %0d: got %b want %b", i, bus.bout, bout_e[i]);
         end
         sb.push_back('{cnt_e[i], tc_e[i], busy_e[i]});
         tick;
         e = sb.pop_front();
         checks++;
         if ({bus.count, bus.tc, bus.busy} !== e) begin
            errors++;
            $display("FAIL one_shot row %0d: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                     i, bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
         end
      end
   endtask
   task automatic test_auto_reload;
      logic [7:0] cnt_e [10] = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
      logic [9:0] tc_e = 10'b1001001000;
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         drive(i == 0, 8'd2, 1'b1, 1'b0, 1'b1);
         #1;
         checks++;
         if (bus.bout !== tc_e[i]) begin
            errors++;
            $display("FAIL auto_bout row %0d: got %b want %b", i, bus.bout, tc_e[i]);
         end
         sb.push_back('{cnt_e[i], tc_e[i], 1'b1});
         tick;
         e = sb.pop_front();
         checks++;
         if ({bus.count, bus.tc, bus.busy} !== e) begin
            errors++;
            $display("FAIL auto row %0d: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                     i, bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
         end
      end
   endtask
   task automatic test_priority;
      logic [7:0] cnt_e [7] = '{8'd1, 8'd0, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         drive(i == 2, 8'h55, 1'b1, i > 2, 1'b1);
         #1;
         checks++;
         if (bus.bout !== 1'b0) begin
            errors++;
            $display("FAIL priority_bout row %0d: got %b want 0", i, bus.bout);
         end
         sb.push_back('{cnt_e[i], 1'b0, 1'b1});
         tick;
         e = sb.pop_front();
         checks++;
         if ({bus.count, bus.tc, bus.busy} !== e) begin
            errors++;
            $display("FAIL priority row %0d: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                     i, bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
         end
      end
   endtask
   task automatic test_cascade;
      logic [15:0] val_e [5] = '{16'h0101, 16'h0100, 16'h0001, 16'h0000, 16'h0101};
      logic [4:0]  hi_exp = 5'b10000;
      logic [15:0] v;
      for (int i = 0; i < 5; i++) begin
         lo_if.load = (i == 0); lo_if.load_val = 8'd1; lo_if.auto_reload = 1'b1; lo_if.cnt_en = (i != 0);
         hi_if.load = (i == 0); hi_if.load_val = 8'd1; hi_if.auto_reload = 1'b1;
         #1;
         checks++;
         if (hi_if.bout !== hi_exp[i]) begin
            errors++;
            $display("FAIL cascade_bout row %0d: got %b want %b", i, hi_if.bout, hi_exp[i]);
         end
         csb.push_back(val_e[i]);
         tick;
         v = csb.pop_front();
         checks++;
         if ({hi_if.count, lo_if.count} !== v || hi_if.tc !== hi_exp[i]) begin
            errors++;
            $display("FAIL cascade row %0d: got value=%h hi_tc=%b want value=%h hi_tc=%b",
                     i, {hi_if.count, lo_if.count}, hi_if.tc, v, hi_exp[i]);
         end
      end
      lo_if.cnt_en = 1'b0;
   endtask
   task automatic test_async_reset;
      logic [7:0] cnt_e [6] = '{8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, 8'h25, 1'b1, 1'b0, 1'b0);
         sb.push_back('{cnt_e[i], 1'b0, 1'b1});
         tick;
         e = sb.pop_front();
         checks++;
         if ({bus.count, bus.tc, bus.busy} !== e) begin
            errors++;
            $display("FAIL async_pre row %0d: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                     i, bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.count, bus.tc, bus.busy, bus.bout} !== 11'h000) begin
         errors++;
         $display("FAIL async_reset: count=%h tc=%b busy=%b bout=%b, want 00 0 0 0", bus.count, bus.tc, bus.busy, bus.bout);
      end
      #2 rst_n = 1'b1;
      sb.push_back('{8'h00, 1'b0, 1'b0});
      tick;
      e = sb.pop_front();
      checks++;
      if ({bus.count, bus.tc, bus.busy} !== e) begin
         errors++;
         $display("FAIL async_post: got count=%h tc=%b busy=%b want count=%h tc=%b busy=%b",
                  bus.count, bus.tc, bus.busy, e.count, e.tc, e.busy);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      test_reset;
      test_one_shot;
      test_auto_reload;
      test_priority;
      test_cascade;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pcle_down_timer.md
# pcle_down_timer

Registered, loadable down-counter/timer. It is the decrementing counterpart to the team's combinational up-count/parallel-load next-state logic. It provides a `WIDTH`-bit down-count with parallel load, count enable and inhibit, a cascadable borrow output, and a one-shot or auto-reload expiry state machine. It is used as a programmable interval timer and as the low stage of cascaded down-counters.

## Interface
- `WIDTH`, 8, counter width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  parallel load strobe; highest priority.
- `load_val`  in  WIDTH  value written to `count` and to the reload register on `load`.
- `cnt_en`  in  1  count enable (also the borrow-in when cascaded).
- `inhibit`  in  1  blocks decrement when high.
- `auto_reload`  in  1  1 = reload on expiry, 0 = one-shot; sampled at expiry.
- `count`  out  WIDTH  current count (registered).
- `bout`  out  1  borrow-out, combinational: `dec & (count == 0)`.
- `tc`  out  1  registered one-cycle expiry pulse.
- `busy`  out  1  high in RUN.

## Operation
- `dec = cnt_en & ~inhibit & ~load & (state == RUN)`.
- States:
  - IDLE: entered on reset.
  - RUN: counting.
  - DONE: one-shot expired.
- `load` (any state):
  - `count <= load_val`.
  - `reload_q <= load_val`.
  - `state <= RUN`.
  - `tc <= 0`.
- RUN, `dec`, `count != 0`: `count <= count - 1`.
- RUN, `dec`, `count == 0` (expiry):
  - `tc <= 1` for one cycle.
  - `bout = 1` combinationally in that cycle.
  - If `auto_reload == 1`: `count <= reload_q`, stay in RUN.
  - If `auto_reload == 0`: `count` stays 0, `state <= DONE`.
- IDLE and DONE: `count` holds; `cnt_en` and `inhibit` are ignored; `bout = 0`.
- Arithmetic is modulo 2^WIDTH, but wrap below 0 never occurs; expiry replaces it.
- Reload with `reload_q == 0` in auto-reload mode expires on every `dec` cycle.
- Cascading: a high stage's `cnt_en` is the low stage's `bout`. The high stage decrements once per low-stage expiry.
- Simultaneous events:
  - `load` with expiry: load wins; no `tc`, `bout = 0`.
  - `inhibit` with `cnt_en`: hold; no `tc`, `bout = 0`.

## Timing
- Reset (async assert, sync release by the integrator): `count = 0`, `reload_q = 0`, `state = IDLE`, `tc = 0`, `busy = 0`. `bout = 0` follows from state.
- Load latency: `count` shows `load_val` one cycle after the `load` edge; `busy = 1` from that cycle.
- Decrement latency: 1 cycle per enabled cycle.
- `tc` goes high in the cycle after the expiry edge condition, i.e. aligned with the reloaded or held `count`. It lasts exactly one cycle unless expiry repeats.
- `bout` is valid in the same cycle as the expiry condition, for zero-latency cascade.
- Reset asserted mid-count: all state clears immediately; no `tc` is generated.
- Period in auto-reload with continuous `dec`: `reload_q + 1` cycles between `tc` pulses.

## Structure
- Shared package `pcle_pkg`:
  - `timer_state_t` enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10.
  - `PCLE_DEF_WIDTH = 8`.
- Sub-module `pcle_dec_stage`:
  - Combinational ripple decrementer with parameter `WIDTH`.
  - Inputs: `q`, `en`. Outputs: `q_next`, `borrow`.
  - Per bit `i`: `q_next[i] = q[i] ^ (en & all lower bits zero)`.
  - `borrow = en & (q == 0)`.
  - Instantiated once in `pcle_down_timer`.
- The top level holds the state register, the reload register and the `tc` flop.

## Test plan
- Reset then idle: `cnt_en = 1` for 10 cycles → `count = 0`, `busy = 0`, `tc = 0`, `bout = 0` throughout.
- One-shot: load 3, `auto_reload = 0`, `cnt_en = 1` → `count` 3, 2, 1, 0. `bout = 1` on the cycle `count = 0`. Next cycle `tc = 1`, state DONE, `count` holds 0; further enables give no `tc`.
- Auto-reload: load 2, `auto_reload = 1`, `cnt_en = 1` for 9 cycles → `count` 2, 1, 0, 2, 1, 0, 2, … with `tc` every 3 cycles.
- Priority: at `count = 0` in RUN, assert `load = 1` (`load_val = 0x55`), `cnt_en = 1` → no `tc`, `bout = 0`, `count = 0x55` next cycle. Then `inhibit = 1` for 4 cycles → `count` stays `0x55`.
- Cascade: two instances chained by `bout` → `cnt_en`, both loaded 1, both auto-reload → high stage decrements only on low-stage expiry. The combined value follows 0x0101 → 0x0100 → 0x0001 → 0x0000, expires on the 4th enabled cycle, then reloads to 0x0101.
- Async reset: assert `rst_n = 0` mid-count at `count = 0x20` between clock edges → `count = 0` and `busy = 0` immediately, with no clock needed.
